// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: default widths, ALU op
// codes, controller FSM states and the legal-op test used when the
// ALU_SHARE_OPCHK_EN build option is enabled.
package alu_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int OP_W_DEF   = 4;

   // ALU control codes understood by the external ALU
   localparam logic [OP_W_DEF-1:0] OP_AND  = 4'b0000;
   localparam logic [OP_W_DEF-1:0] OP_OR   = 4'b0001;
   localparam logic [OP_W_DEF-1:0] OP_ADD  = 4'b0010;
   localparam logic [OP_W_DEF-1:0] OP_XOR  = 4'b0011;
   localparam logic [OP_W_DEF-1:0] OP_SLL  = 4'b0100;
   localparam logic [OP_W_DEF-1:0] OP_SRL  = 4'b0101;
   localparam logic [OP_W_DEF-1:0] OP_SUB  = 4'b0110;
   localparam logic [OP_W_DEF-1:0] OP_SLT  = 4'b0111;
   localparam logic [OP_W_DEF-1:0] OP_SRA  = 4'b1000;
   localparam logic [OP_W_DEF-1:0] OP_NOR  = 4'b1100;
   localparam logic [OP_W_DEF-1:0] OP_SLTU = 4'b1110;
   localparam logic [OP_W_DEF-1:0] OP_SLT2 = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   // Legal codes are the contiguous block AND..SRA plus NOR, SLTU and SLT2
   function automatic logic is_legal_op(input logic [OP_W_DEF-1:0] op);
      return (op <= OP_SRA) || (op == OP_NOR) || (op == OP_SLTU) || (op == OP_SLT2);
   endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant. A lone requester wins outright; on a tie the
// port that was not granted last time wins. Output is one-hot or zero.
module alu_rr_arb2 (
   input  logic [1:0] i_req,
   input  logic       i_last_grant,
   output logic [1:0] o_grant
);

   // Combinational grant selection
   always_comb begin
      // NOTE: default assignment first so every path drives o_grant and no latch is inferred.
      o_grant = i_req;
      if (&i_req) begin
         o_grant = i_last_grant ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external combinational ALU between two requesters (port 0:
// core execute stage, port 1: auxiliary unit). One operation in flight:
// IDLE accepts, EXEC drives the ALU for one cycle, RESP holds the result
// until the owner takes it. Build option ALU_SHARE_OPCHK_EN screens op codes
// at accept time and answers illegal ones with rsp_err without using the ALU.
module alu_share_ctrl
   import alu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int OP_W   = OP_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [1:0]             i_req_valid,
   output logic [1:0]             o_req_ready,
   input  logic [1:0][DATA_W-1:0] i_req_a,
   input  logic [1:0][DATA_W-1:0] i_req_b,
   input  logic [1:0][OP_W-1:0]   i_req_op,
   output logic [1:0]             o_rsp_valid,
   input  logic [1:0]             i_rsp_ready,
   output logic [DATA_W-1:0]      o_rsp_res,
   output logic                   o_rsp_zero,
   output logic                   o_rsp_err,
   output logic [DATA_W-1:0]      o_alu_a,
   output logic [DATA_W-1:0]      o_alu_b,
   output logic [OP_W-1:0]        o_alu_control,
   input  logic [DATA_W-1:0]      i_alu_res,
   input  logic                   i_alu_zero
);

   state_t              r_state;
   logic                r_last_grant;
   logic                r_owner;
   logic [1:0]          r_rsp_valid;
   logic [DATA_W-1:0]   r_res;
   logic                r_zero;
   logic                r_err;
   logic [DATA_W-1:0]   r_alu_a;
   logic [DATA_W-1:0]   r_alu_b;
   logic [OP_W-1:0]     r_alu_control;

   logic [1:0]          w_grant;
   logic                w_accept_en;
   logic                w_fire;
   logic                w_sel;
   logic [DATA_W-1:0]   w_sel_a;
   logic [DATA_W-1:0]   w_sel_b;
   logic [OP_W-1:0]     w_sel_op;
   logic                w_op_ok;

   alu_rr_arb2 u_arb (
      .i_req        (i_req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant)
   );

   // Grant is only exposed while idle and out of reset, so no handshake can
   // complete in a reset cycle or while an operation is in flight.
   assign w_accept_en = (r_state == ST_IDLE) && rst_n;
   assign o_req_ready = w_accept_en ? w_grant : 2'b00;
   assign w_fire      = |(o_req_ready & i_req_valid);

   // Operand mux for the granted port
   assign w_sel    = w_grant[1];
   assign w_sel_a  = i_req_a[w_sel];
   assign w_sel_b  = i_req_b[w_sel];
   assign w_sel_op = i_req_op[w_sel];

`ifdef ALU_SHARE_OPCHK_EN
   assign w_op_ok = is_legal_op(w_sel_op);
`else
   // Without screening every code goes to the ALU and rsp_err stays low.
   assign w_op_ok = 1'b1;
`endif

   // Controller FSM with registered ALU drive and response outputs
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_last_grant  <= 1'b1;
         r_owner       <= 1'b0;
         r_rsp_valid   <= 2'b00;
         r_res         <= '0;
         r_zero        <= 1'b0;
         r_err         <= 1'b0;
         r_alu_a       <= '0;
         r_alu_b       <= '0;
         r_alu_control <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_fire) begin
                  r_owner      <= w_sel;
                  r_last_grant <= w_sel;
                  if (w_op_ok) begin
                     // Operand registers double as the ALU drive, so the ALU
                     // inputs only move on an accepted legal operation.
                     r_alu_a       <= w_sel_a;
                     r_alu_b       <= w_sel_b;
                     r_alu_control <= w_sel_op;
                     r_state       <= ST_EXEC;
                  end else begin
                     // Illegal op: answer directly without touching the ALU.
                     r_res       <= '0;
                     r_zero      <= 1'b0;
                     r_err       <= 1'b1;
                     r_rsp_valid <= w_grant;
                     r_state     <= ST_RESP;
                  end
               end
            end
            ST_EXEC: begin
               r_res       <= i_alu_res;
               r_zero      <= i_alu_zero;
               r_err       <= 1'b0;
               r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
               r_state     <= ST_RESP;
            end
            ST_RESP: begin
               if (i_rsp_ready[r_owner]) begin
                  r_rsp_valid <= 2'b00;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_rsp_valid <= 2'b00;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_rsp_valid   = r_rsp_valid;
   assign o_rsp_res     = r_res;
   assign o_rsp_zero    = r_zero;
   assign o_rsp_err     = r_err;
   assign o_alu_a       = r_alu_a;
   assign o_alu_b       = r_alu_b;
   assign o_alu_control = r_alu_control;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU attached.
// Also covers the ALU_SHARE_OPCHK_EN build when that macro is defined.
module tb_alu_share_ctrl;

   logic              clk;
   logic              rst_n;
   logic [1:0]        req_valid;
   logic [1:0]        req_ready;
   logic [1:0][31:0]  req_a;
   logic [1:0][31:0]  req_b;
   logic [1:0][3:0]   req_op;
   logic [1:0]        rsp_valid;
   logic [1:0]        rsp_ready;
   logic [31:0]       rsp_res;
   logic              rsp_zero;
   logic              rsp_err;
   logic [31:0]       alu_a;
   logic [31:0]       alu_b;
   logic [3:0]        alu_control;
   logic [31:0]       alu_res;
   logic              alu_zero;

   int n_checks = 0;
   int n_errors = 0;

   alu_share_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_req_valid   (req_valid),
      .o_req_ready   (req_ready),
      .i_req_a       (req_a),
      .i_req_b       (req_b),
      .i_req_op      (req_op),
      .o_rsp_valid   (rsp_valid),
      .i_rsp_ready   (rsp_ready),
      .o_rsp_res     (rsp_res),
      .o_rsp_zero    (rsp_zero),
      .o_rsp_err     (rsp_err),
      .o_alu_a       (alu_a),
      .o_alu_b       (alu_b),
      .o_alu_control (alu_control),
      .i_alu_res     (alu_res),
      .i_alu_zero    (alu_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-cycle ALU; unknown codes return 0
   always_comb begin
      alu_res = 32'h0;
      case (alu_control)
         4'b0000: alu_res = alu_a & alu_b;
         4'b0001: alu_res = alu_a | alu_b;
         4'b0010: alu_res = alu_a + alu_b;
         4'b0011: alu_res = alu_a ^ alu_b;
         4'b0100: alu_res = alu_a << alu_b[4:0];
         4'b0101: alu_res = alu_a >> alu_b[4:0];
         4'b0110: alu_res = alu_a - alu_b;
         4'b0111: alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
         4'b1000: alu_res = $unsigned($signed(alu_a) >>> alu_b[4:0]);
         4'b1100: alu_res = ~(alu_a | alu_b);
         4'b1110: alu_res = {31'h0, alu_a < alu_b};
         4'b1111: alu_res = {31'h0, $signed(alu_a) < $signed(alu_b)};
         default: alu_res = 32'h0;
      endcase
      alu_zero = (alu_res == 32'h0);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      req_op[p] = op;
      req_a[p]  = a;
      req_b[p]  = b;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      repeat (2) tick();
      rst_n = 1'b1;
      #1;
   endtask

   logic [1:0]  exp_g [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
   logic [31:0] exp_r [4]  = '{32'h0, 32'hFF, 32'h0, 32'hFF};
   logic [3:0]  b2b_op [3] = '{4'b0010, 4'b0110, 4'b0011};
   logic [31:0] b2b_a  [3] = '{32'd1, 32'd10, 32'hF0};
   logic [31:0] b2b_b  [3] = '{32'd1, 32'd3, 32'hFF};
   logic [31:0] b2b_r  [3] = '{32'd2, 32'd7, 32'h0F};

   initial begin
      req_a = '0;
      req_b = '0;
      req_op = '0;

      // Reset state
      do_reset();
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_rsp_res", rsp_res, 0);
      check("rst_rsp_zero", 32'(rsp_zero), 0);
      check("rst_rsp_err", 32'(rsp_err), 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_ctl", 32'(alu_control), 0);

      // Single ADD on port 0: 5 + 7 = 12, response two cycles after accept
      set_req(0, 4'b0010, 32'd5, 32'd7);
      req_valid = 2'b01;
      #1;
      check("add_req_ready", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      #1;
      check("add_exec_rsp_valid", 32'(rsp_valid), 0);
      check("add_exec_req_ready", 32'(req_ready), 0);
      check("add_alu_a", alu_a, 32'd5);
      check("add_alu_b", alu_b, 32'd7);
      check("add_alu_ctl", 32'(alu_control), 32'h2);
      tick();
      check("add_rsp_valid", 32'(rsp_valid), 32'h1);
      check("add_rsp_res", rsp_res, 32'd12);
      check("add_rsp_zero", 32'(rsp_zero), 0);
      check("add_rsp_err", 32'(rsp_err), 0);
      tick();
      check("add_done_rsp_valid", 32'(rsp_valid), 0);

      // Both ports held valid from reset: grants alternate starting at port 0
      do_reset();
      set_req(0, 4'b0110, 32'd9, 32'd9);
      set_req(1, 4'b0001, 32'hF0, 32'h0F);
      req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr%0d_grant", i), 32'(req_ready), 32'(exp_g[i]));
         tick();
         check($sformatf("rr%0d_exec_ready", i), 32'(req_ready), 0);
         check($sformatf("rr%0d_exec_valid", i), 32'(rsp_valid), 0);
         tick();
         check($sformatf("rr%0d_rsp_valid", i), 32'(rsp_valid), 32'(exp_g[i]));
         check($sformatf("rr%0d_rsp_res", i), rsp_res, exp_r[i]);
         check($sformatf("rr%0d_rsp_zero", i), 32'(rsp_zero), (exp_r[i] == 0) ? 32'h1 : 32'h0);
         tick();
      end

      // Port 1 response stalled 10 cycles while port 0 waits
      req_valid = 2'b10;
      set_req(0, 4'b0010, 32'd5, 32'd7);
      rsp_ready = 2'b01;
      #1;
      check("stall_grant1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b01;
      #1;
      check("stall_exec_ready", 32'(req_ready), 0);
      tick();
      check("stall_rsp_valid", 32'(rsp_valid), 32'h2);
      check("stall_rsp_res", rsp_res, 32'hFF);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("stall%0d_valid", i), 32'(rsp_valid), 32'h2);
         check($sformatf("stall%0d_res", i), rsp_res, 32'hFF);
         check($sformatf("stall%0d_ready", i), 32'(req_ready), 0);
      end
      rsp_ready = 2'b11;
      tick();
      check("stall_release_grant0", 32'(req_ready), 32'h1);
      check("stall_release_valid", 32'(rsp_valid), 0);
      tick();
      req_valid = 2'b00;
      tick();
      check("stall_p0_rsp_valid", 32'(rsp_valid), 32'h1);
      check("stall_p0_rsp_res", rsp_res, 32'd12);
      tick();

      // Reset pulse while EXEC: operation dropped, outputs cleared
      set_req(1, 4'b0010, 32'd1, 32'd2);
      req_valid = 2'b10;
      #1;
      check("rexec_grant1", 32'(req_ready), 32'h2);
      tick();
      req_valid = 2'b00;
      check("rexec_alu_a", alu_a, 32'd1);
      rst_n = 1'b0;
      tick();
      check("rexec_rsp_valid", 32'(rsp_valid), 0);
      check("rexec_rsp_res", rsp_res, 0);
      check("rexec_rsp_zero", 32'(rsp_zero), 0);
      check("rexec_alu_a0", alu_a, 0);
      check("rexec_alu_b0", alu_b, 0);
      check("rexec_alu_ctl0", 32'(alu_control), 0);
      check("rexec_req_ready", 32'(req_ready), 0);
      rst_n = 1'b1;
      set_req(0, 4'b0010, 32'd2, 32'd3);
      req_valid = 2'b11;
      #1;
      check("rexec_tie_grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
      check("rexec_no_rsp", 32'(rsp_valid), 0);
      tick();
      check("rexec_p0_rsp_valid", 32'(rsp_valid), 32'h1);
      check("rexec_p0_rsp_res", rsp_res, 32'd5);
      tick();

      // Op code 1010 on port 0
      set_req(0, 4'b1010, 32'd3, 32'd4);
      req_valid = 2'b01;
      #1;
      check("ill_grant0", 32'(req_ready), 32'h1);
      tick();
      req_valid = 2'b00;
`ifdef ALU_SHARE_OPCHK_EN
      check("ill_rsp_valid_n1", 32'(rsp_valid), 32'h1);
      check("ill_rsp_err", 32'(rsp_err), 32'h1);
      check("ill_rsp_res", rsp_res, 0);
      check("ill_rsp_zero", 32'(rsp_zero), 0);
      check("ill_alu_ctl_kept", 32'(alu_control), 32'h2);
      check("ill_alu_a_kept", alu_a, 32'd2);
      tick();
      check("ill_done_valid", 32'(rsp_valid), 0);
`else
      check("ill_exec_valid", 32'(rsp_valid), 0);
      check("ill_alu_ctl", 32'(alu_control), 32'hA);
      tick();
      check("ill_rsp_valid_n2", 32'(rsp_valid), 32'h1);
      check("ill_rsp_err", 32'(rsp_err), 0);
      check("ill_rsp_res", rsp_res, 0);
      check("ill_rsp_zero", 32'(rsp_zero), 32'h1);
      tick();
      check("ill_done_valid", 32'(rsp_valid), 0);
`endif

      // Back-to-back port 0 ops with rsp_ready high: one accept every 3 cycles
      req_valid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         set_req(0, b2b_op[k], b2b_a[k], b2b_b[k]);
         #1;
         check($sformatf("b2b%0d_accept", k), 32'(req_ready), 32'h1);
         tick();
         check($sformatf("b2b%0d_exec_ready", k), 32'(req_ready), 0);
         tick();
         check($sformatf("b2b%0d_rsp_valid", k), 32'(rsp_valid), 32'h1);
         check($sformatf("b2b%0d_rsp_res", k), rsp_res, b2b_r[k]);
         check($sformatf("b2b%0d_resp_ready", k), 32'(req_ready), 0);
         tick();
      end
      req_valid = 2'b00;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing and arbitration controller that shares the single-cycle ALU between two requesters (port 0: core execute stage, port 1: auxiliary unit, e.g. address generation/debug). Accepts operations over valid/ready handshakes, round-robins access, drives the ALU from registered operands, and returns the registered result and zero flag to the granted requester. The ALU itself stays external and combinational; this block owns only its control and operand/result registers.

## Interface
- DATA_W, 32, operand/result width
- OP_W, 4, ALU control code width
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid[i]  in  1  operation request, i = 0,1
- req_ready[i]  out  1  request accepted when valid & ready
- req_a[i], req_b[i]  in  DATA_W  operands
- req_op[i]  in  OP_W  ALU control code
- rsp_valid[i]  out  1  result available for requester i
- rsp_ready[i]  in  1  requester i consumes result
- rsp_res  out  DATA_W  result (shared by both ports, qualified by rsp_valid[i])
- rsp_zero  out  1  ALU zero flag for rsp_res
- rsp_err  out  1  illegal op code (see Configuration)
- alu_a, alu_b  out  DATA_W  to ALU operands
- alu_control  out  OP_W  to ALU control
- alu_res  in  DATA_W  from ALU result
- alu_zero  in  1  from ALU zero flag

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: req_ready[g] = 1 only for granted port g; grant = sole valid port, or on both valid the port ≠ last_grant. On handshake: capture a, b, op, owner=g into registers; flip last_grant to g; → EXEC.
- EXEC (exactly 1 cycle): alu_a/alu_b/alu_control driven from operand registers; capture alu_res, alu_zero into output registers; → RESP.
- RESP: rsp_valid[owner]=1, other port 0; holds rsp_res/rsp_zero/rsp_err stable until rsp_ready[owner]; on it → IDLE. rsp_ready of non-owner ignored.
- req_ready both 0 in EXEC and RESP (no overlap; one operation in flight).
- Outside EXEC, alu_* keep last registered values (no glitching to ALU on idle).
- Reset values: req_ready 0, rsp_valid 0, rsp_res 0, rsp_zero 0, rsp_err 0, alu_a 0, alu_b 0, alu_control 0, last_grant 1 (port 0 wins first tie).
- Reset asserted in any state: in-flight operation discarded, no response issued, all outputs to reset values next edge.

## Timing
- Request accepted cycle N → rsp_valid asserted cycle N+2.
- Minimum occupancy 3 cycles per operation (accept, EXEC, RESP with rsp_ready high); next accept earliest cycle after RESP handshake.
- Grant combinational from req_valid and last_grant in IDLE only; req_ready must not depend on req_ready of the other port.
- rsp_ready held low stalls indefinitely; other port's request waits, not dropped, fairness preserved.

## Configuration
- ALU_SHARE_OPCHK_EN defined: in IDLE the captured op is checked against legal codes 0000–1000, 1100, 1110, 1111. Illegal op: ALU not driven (alu_* unchanged), EXEC skipped → RESP directly, rsp_res 0, rsp_zero 0, rsp_err 1; latency N+1.
- Undefined: no check; illegal codes pass through to the ALU (which returns 0, zero 1); rsp_err tied 0; latency always N+2.

## Structure
- Shared package alu_pkg: OP_W, DATA_W defaults, ALU op code constants (AND, OR, ADD, XOR, SLL, SRL, SUB, SLT, SRA, NOR, SLTU, SLT2), FSM state enum, legal-op function.
- One sub-module: alu_rr_arb2 (2-way round-robin grant, inputs req[1:0], last_grant; output grant one-hot).

## Test plan
- Single request port 0, op ADD (0010), a=5, b=7 → rsp_valid[0] at N+2, rsp_res=12, rsp_zero=0, rsp_valid[1] stays 0.
- Both ports valid from reset: port 0 SUB 9-9, port 1 OR 0xF0|0x0F → port 0 granted first (rsp_res 0, rsp_zero 1), then port 1 (rsp_res 0xFF); repeat with both held → grants alternate 0,1,0,1.
- rsp_ready[1] held low 10 cycles after port 1 result → rsp_res stable, req_ready[0] 0 throughout, port 0 granted cycle after handshake.
- Reset pulse during EXEC → no rsp_valid, all outputs 0, next request granted to port 0.
- Op 1010 with ALU_SHARE_OPCHK_EN → rsp_err 1, rsp_res 0, latency N+1, alu_control unchanged; without macro → rsp_err 0, rsp_res 0, rsp_zero 1, latency N+2.
- Back-to-back requests on port 0 with rsp_ready always high → one accept every 3 cycles, results in order.
